// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter: shares one single-port pixel memory between the VGA scan-out reader and a FIFO-buffered writer
//
// Ports:
//   clk25, rst              pixel clock, synchronous active-high reset
//   rd_req/rd_addr          scan-out read request and address (highest priority, never stalled)
//   rd_data/rd_valid        read result, two cycles after rd_req; BLANK_COLOR when not valid
//   wr_valid/wr_ready       writer handshake into the write FIFO
//   wr_addr/wr_data         write address and pixel
//   mem_addr/mem_we/...     single-port memory interface (registered read, one cycle latency)
//   fifo_level              current write FIFO occupancy
//   stall_cnt               saturating count of refused write offers (PIXEL_MEM_ARBITER_STATS_EN only)
//
// Optional feature macro: PIXEL_MEM_ARBITER_STATS_EN
module pixel_mem_arbiter #(
    parameter int             AW          = 13,
    parameter int             DW          = 8,
    parameter int             FIFO_DEPTH  = 4,
    parameter logic [DW-1:0]  BLANK_COLOR = 8'h00
) (
    input  logic                          clk25,
    input  logic                          rst,
    input  logic                          rd_req,
    input  logic [AW-1:0]                 rd_addr,
    output logic [DW-1:0]                 rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [DW-1:0]                 wr_data,
    output logic [AW-1:0]                 mem_addr,
    output logic                          mem_we,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
`ifdef PIXEL_MEM_ARBITER_STATS_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    logic [AW-1:0] q_addr [FIFO_DEPTH];
    logic [DW-1:0] q_data [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic          empty, full, push;
    logic [AW-1:0] last_addr;
    logic          rd_v1, rd_v2;
    logic [DW-1:0] rd_q;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty      = wp == rp;
    assign full       = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
    assign wr_ready   = !rst && !full;
    assign push       = wr_valid && wr_ready;
    assign fifo_level = wp - rp;
    assign rd_valid   = rd_v2;
    assign rd_data    = rd_v2 ? rd_q : BLANK_COLOR;

    // Reader owns the port whenever it asks; the FIFO head drains only in idle cycles.
    // With no owner the address bus keeps its previous value.
    always_comb begin
        mem_we    = !rst && !rd_req && !empty;
        mem_addr  = rst ? '0 : rd_req ? rd_addr : !empty ? q_addr[rp[PW-2:0]] : last_addr;
        mem_wdata = mem_we ? q_data[rp[PW-2:0]] : '0;
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            last_addr <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            rd_q      <= BLANK_COLOR;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (mem_we)
                rp <= rp + 1'b1;
            last_addr <= mem_addr;
            rd_v1     <= rd_req;
            rd_v2     <= rd_v1;
            rd_q      <= rd_v1 ? mem_rdata : BLANK_COLOR;
        end
    end

    always_ff @(posedge clk25) begin
        if (push) begin
            q_addr[wp[PW-2:0]] <= wr_addr;
            q_data[wp[PW-2:0]] <= wr_data;
        end
    end

`ifdef PIXEL_MEM_ARBITER_STATS_EN
    always_ff @(posedge clk25) begin
        if (rst)
            stall_cnt <= '0;
        else if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/pixel_mem_arbiter.md
Name: pixel_mem_arbiter

Overview:
- Shares one single-port pixel memory (8-bit RGB332 words, 13-bit address) between two users.
- User 1 is the VGA scan-out reader: fixed highest priority, one read per active-pixel cycle, on clk25.
- User 2 is a drawing/pattern writer: valid/ready handshake, buffered in a small write FIFO.
- FIFO entries drain into memory only in cycles where the reader is idle (blanking).
- Sits between VGA_module (pixel_addr/pixel_data) and the pixel memory, in place of the direct memory hookup.

Parameters:
- AW, 13, memory address width.
- DW, 8, pixel data width (RGB332).
- FIFO_DEPTH, 4, write FIFO entries; power of two, minimum 2.
- BLANK_COLOR, 8'h00, rd_data value when rd_valid=0.

Ports:
- clk25  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  scan-out read request for this cycle (active video).
- rd_addr  in  AW  scan-out pixel address.
- rd_data  out  DW  pixel returned to VGA_module.
- rd_valid  out  1  rd_data holds a memory read result.
- wr_valid  in  1  writer offers wr_addr/wr_data.
- wr_ready  out  1  FIFO accepts this cycle.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write pixel.
- mem_addr  out  AW  memory address (combinational mux).
- mem_we  out  1  memory write enable (combinational).
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; registered memory, valid 1 cycle after the address is presented.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (rst=1 sampled at clk25 edge):
  - FIFO emptied; fifo_level=0; wr_ready=0 while rst=1.
  - rd_valid=0; rd_data=BLANK_COLOR; read pipeline cleared.
  - mem_we=0; mem_addr=0; mem_wdata=0.
- Reset mid-operation: pending FIFO writes are discarded, in-flight reads are dropped, and no memory write is issued in the reset cycle.
- Port ownership per cycle:
  - rd_req=1: read. mem_addr=rd_addr, mem_we=0.
  - rd_req=0 and FIFO not empty: write. mem_addr/mem_wdata = FIFO head, mem_we=1, head popped at the edge.
  - Otherwise idle: mem_we=0, mem_addr holds the last value.
- The reader is never stalled. A write never occurs in a cycle with rd_req=1.
- Read latency is exactly 2 cycles:
  - Cycle N: rd_req=1 with rd_addr.
  - Cycle N+1: mem_rdata is captured into the rd_data register.
  - Cycle N+2: rd_data and rd_valid=1 are visible.
  - rd_valid is rd_req delayed by 2 cycles.
  - When rd_valid=0, rd_data=BLANK_COLOR.
- Write handshake:
  - wr_ready = !full, from registered FIFO state.
  - A push occurs when wr_valid && wr_ready.
  - When full, no push is accepted even if a pop happens the same cycle; wr_ready rises the cycle after the pop.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - A push into an empty FIFO is written to memory no earlier than the next cycle (no bypass).
  - FIFO order is strict: writes reach memory in acceptance order.
- Pointer arithmetic: read and write pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full = MSBs differ and lower bits are equal; empty = pointers equal.
- Hazards:
  - A read of an address with a pending FIFO write returns the old memory contents. No forwarding.
  - Two queued writes to the same address both reach memory, in order; the last one wins.
- Continuous rd_req=1 lets the FIFO fill and hold wr_ready=0 indefinitely. Writers must tolerate this; drain resumes on the first rd_req=0 cycle.

Optional Feature:
- Macro: PIXEL_MEM_ARBITER_STATS_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - stall_cnt counts cycles with wr_valid=1 && wr_ready=0, excluding rst cycles.
  - Saturates at 16'hFFFF; cleared to 0 by rst.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst for 3 cycles.
  - During reset: wr_ready=0, rd_valid=0, rd_data=8'h00, mem_we=0, fifo_level=0.
  - First cycle after reset: wr_ready=1.
- Blanking write then read:
  - rd_req=0; push addr 13'h0005 data 8'hC0 → mem_we=1 at addr 5 the next cycle; fifo_level back to 0.
  - Then rd_req=1 with rd_addr=5 → rd_valid=1 and rd_data=8'hC0 exactly 2 cycles later.
- Active-video backpressure:
  - rd_req held 1; push 4 writes → fifo_level=4, wr_ready=0, mem_we stays 0.
  - Drop rd_req → four consecutive mem_we=1 cycles in push order; wr_ready=1 one cycle after the first pop.
- Read during pending write:
  - Memory addr 7 holds 8'h07; queue write addr 7 = 8'h38 while rd_req=1; read addr 7 the same cycle → returns 8'h07.
  - After drain, a read of addr 7 returns 8'h38.
- Reset mid-drain: 3 queued writes; assert rst on the cycle of the first pop → no mem_we in that cycle or after; fifo_level=0; memory unchanged for the remaining 2 addresses.
- Stats (PIXEL_MEM_ARBITER_STATS_EN defined): fill FIFO under rd_req=1, hold wr_valid=1 for 10 further cycles → stall_cnt=10; rst → 0.
